ysyx_23060136_exu_div: RTL and testbench
========================================

# ysyx_23060136_exu_div

Iterative radix-2 integer divider serving the EXU ALU's DIV/REM requests (RV64M `div`, `divu`, `rem`, `remu`, `divw`, `divuw`, `remw`, `remuw`). It accepts one request over a valid/ready handshake and computes one quotient bit per cycle. It returns quotient and remainder together with a one-cycle `div_out_valid` pulse. It sits directly downstream of the ALU's divider interface and can be flushed by a branch or redirect.

## Interface
- `BITS_W`, default 64, datapath width; must equal `ysyx_23060136_BITS_W`.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: abort any in-flight or requested operation.
- `div_valid` in 1: request valid.
- `divw` in 1: 32-bit (W) operation.
- `div_signed` in 1: signed operation.
- `dividend` in BITS_W: dividend operand.
- `divisor` in BITS_W: divisor operand.
- `div_ready` out 1: able to accept a request. Asserted only in IDLE.
- `div_out_valid` out 1: result valid, pulsed for one cycle.
- `quotient` out BITS_W: quotient result, held until the next accepted request.
- `remainder` out BITS_W: remainder result, held until the next accepted request.

## Operation
- **States:** IDLE, CALC, DONE.
- **Accept:** a request is accepted at a rising edge when `div_valid & div_ready & ~flush`. The block latches operands, `divw` and `div_signed`, and loads the iteration counter with N.
  - N = 64, or 32 when `divw`.
- **W operands:** operands are the low 32 bits, sign-extended if `div_signed`, otherwise zero-extended.
- **Signed pre-processing:** convert both operands to magnitude. Record `q_neg = sign(a) ^ sign(b)` and `r_neg = sign(a)`.
- **CALC, one step per cycle:**
  - Shift {rem, dividend} left by 1.
  - Trial-subtract the divisor magnitude from rem.
  - If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the bit to 0.
  - Decrement the counter. When the counter reaches 1, the next state is DONE.
- **DONE:** apply sign fix-up, then W sign-extension. Drive results, assert `div_out_valid`, and return to IDLE at the next edge.
- **Sign fix-up:** negate the quotient if `q_neg`; negate the remainder if `r_neg`.
- **W results:** bits [31:0] sign-extended to 64 bits, including for `divuw`/`remuw`.
- **Divide by zero:** `quotient` = all ones, `remainder` = dividend.
  - The dividend is the W-extended value for W operations.
  - This overrides the sign fix-up.
- **Signed overflow:** dividend = most negative value (64- or 32-bit as applicable) and divisor = -1 gives `quotient` = dividend and `remainder` = 0.
- **Flush:** synchronous to `clk`.
  - A flush in any state moves to IDLE at the next edge.
  - A request presented together with `flush` is dropped.
  - `div_out_valid = (state == DONE) & ~flush`.
  - `quotient`/`remainder` keep their previous values on flush.
- **Reset:** asynchronous `rst` forces IDLE, counter 0, `quotient` = 0, `remainder` = 0 at any time, including mid-CALC.

## Timing
- **Reset values:** `div_ready` = 1, `div_out_valid` = 0, `quotient` = 0, `remainder` = 0.
- **Latency:** with acceptance at edge E0, CALC occupies the cycles after E0..E(N-1). DONE is the cycle after EN, so `div_out_valid` is high exactly one cycle.
  - 64-bit operations: result is N+1 = 65 cycles after acceptance.
  - W operations: 33 cycles.
- **Throughput:** one operation per N+2 cycles. `div_ready` is low from the cycle after acceptance through DONE.
- **Results:** `quotient`/`remainder` registers update on the edge entering DONE and are stable while `div_out_valid` is high and afterwards.
- **No backpressure:** there is no output ready. The consumer must capture the result in the `div_out_valid` cycle.
- **Operand stability:** operands need only be valid in the acceptance cycle.

## Configuration
- **`YSYX_23060136_DIV_FAST_SPECIAL_EN` defined:** divide-by-zero and signed-overflow requests skip CALC. IDLE goes to DONE at the acceptance edge, so the result appears one cycle after acceptance.
- **Macro undefined:** special cases iterate the full N cycles. The override values are applied in DONE, giving identical results with normal latency.

## Test plan
- Unsigned 64-bit, 100 / 7 -> `quotient` = 14, `remainder` = 2. `div_out_valid` is a single pulse 65 cycles after acceptance; `div_ready` returns the cycle after.
- Signed -7 / 2 -> `quotient` = 0xFFFF_FFFF_FFFF_FFFD, `remainder` = 0xFFFF_FFFF_FFFF_FFFF. Also check 7 / -2 -> `quotient` = -3, `remainder` = 1.
- `divw` signed, 0x8000_0000 / 0xFFFF_FFFF -> `quotient` = 0xFFFF_FFFF_8000_0000, `remainder` = 0. Check 33-cycle latency, or 1 cycle with the macro.
- Divide by zero:
  - Signed 64-bit, -5 / 0 -> `quotient` = all ones, `remainder` = 0xFFFF_FFFF_FFFF_FFFB.
  - `divuw` 0x1_8000_0000 / 0 -> `remainder` = 0xFFFF_FFFF_8000_0000.
- Flush and reset recovery:
  - Assert `flush` 10 cycles into CALC -> no `div_out_valid`, `div_ready` = 1 next cycle. An immediate 81 / 9 then gives `quotient` = 9, `remainder` = 0.
  - Assert `rst` mid-CALC -> all outputs at their reset values asynchronously.
- Request with `div_valid` and `flush` in the same cycle -> not accepted, state stays IDLE. A request while busy (`div_ready` = 0) is ignored.

Source files
------------

// File: rtl/ysyx_23060136_exu_div.sv
// Iterative radix-2 restoring divider for RV64M DIV/REM and their W forms.
// Optional: YSYX_23060136_DIV_FAST_SPECIAL_EN lets divide-by-zero and signed overflow skip CALC.
module ysyx_23060136_exu_div #(
  parameter int unsigned BITS_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              div_valid,
  input  logic              divw,
  input  logic              div_signed,
  input  logic [BITS_W-1:0] dividend,
  input  logic [BITS_W-1:0] divisor,
  output logic              div_ready,
  output logic              div_out_valid,
  output logic [BITS_W-1:0] quotient,
  output logic [BITS_W-1:0] remainder
);

  localparam int unsigned HalfW = BITS_W / 2;
  localparam int unsigned CntW  = $clog2(BITS_W + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BITS_W-1:0] rem_q, rem_d;
  logic [BITS_W-1:0] dvd_q, dvd_d;
  logic [BITS_W-1:0] dsr_q, dsr_d;
  logic [BITS_W-1:0] dvd_ext_q, dvd_ext_d;
  logic              q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic              w_q, w_d, dz_q, dz_d, ovf_q, ovf_d;
  logic [BITS_W-1:0] quotient_q, quotient_d;
  logic [BITS_W-1:0] remainder_q, remainder_d;

  function automatic logic [BITS_W-1:0] wsext(input logic w, input logic [BITS_W-1:0] v);
    return w ? {{HalfW{v[HalfW-1]}}, v[HalfW-1:0]} : v;
  endfunction

  // Operand conditioning for the incoming request
  logic [BITS_W-1:0] a_ext, b_ext, a_mag, b_mag, dvd_init;
  logic              a_neg, b_neg, b_zero, ovf, accept;

  always_comb begin
    if (divw) begin
      a_ext = {{HalfW{div_signed & dividend[HalfW-1]}}, dividend[HalfW-1:0]};
      b_ext = {{HalfW{div_signed & divisor[HalfW-1]}}, divisor[HalfW-1:0]};
    end else begin
      a_ext = dividend;
      b_ext = divisor;
    end
    a_neg  = div_signed & a_ext[BITS_W-1];
    b_neg  = div_signed & b_ext[BITS_W-1];
    a_mag  = a_neg ? -a_ext : a_ext;
    b_mag  = b_neg ? -b_ext : b_ext;
    b_zero = (b_ext == '0);
    if (divw) begin
      ovf = div_signed & (b_ext == {BITS_W{1'b1}}) &
            (a_ext == {{(HalfW + 1){1'b1}}, {(HalfW - 1){1'b0}}});
    end else begin
      ovf = div_signed & (b_ext == {BITS_W{1'b1}}) & (a_ext == {1'b1, {(BITS_W - 1){1'b0}}});
    end
    // W magnitudes sit in the upper half so 32 shifts bring them through
    dvd_init = divw ? {a_mag[HalfW-1:0], {HalfW{1'b0}}} : a_mag;
    accept   = div_valid & div_ready & ~flush;
  end

  // One restoring step; the trial remainder needs one extra bit for large divisors
  logic [BITS_W:0]   shifted, diff;
  logic              step_ok;
  logic [BITS_W-1:0] rem_step, dvd_step;

  always_comb begin
    shifted  = {rem_q, dvd_q[BITS_W-1]};
    diff     = shifted - {1'b0, dsr_q};
    step_ok  = ~diff[BITS_W];
    rem_step = step_ok ? diff[BITS_W-1:0] : shifted[BITS_W-1:0];
    dvd_step = {dvd_q[BITS_W-2:0], step_ok};
  end

  logic [BITS_W-1:0] q_raw, q_fix, r_fix, res_q, res_r;

  always_comb begin
    q_raw = w_q ? {{HalfW{1'b0}}, dvd_step[HalfW-1:0]} : dvd_step;
    q_fix = q_neg_q ? -q_raw : q_raw;
    r_fix = r_neg_q ? -rem_step : rem_step;
    if (dz_q) begin
      q_fix = {BITS_W{1'b1}};
      r_fix = dvd_ext_q;
    end else if (ovf_q) begin
      q_fix = dvd_ext_q;
      r_fix = '0;
    end
    res_q = wsext(w_q, q_fix);
    res_r = wsext(w_q, r_fix);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    dvd_ext_d   = dvd_ext_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    w_d         = w_q;
    dz_d        = dz_q;
    ovf_d       = ovf_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d   = StCalc;
          cnt_d     = divw ? CntW'(HalfW) : CntW'(BITS_W);
          rem_d     = '0;
          dvd_d     = dvd_init;
          dsr_d     = b_mag;
          dvd_ext_d = a_ext;
          q_neg_d   = a_neg ^ b_neg;
          r_neg_d   = a_neg;
          w_d       = divw;
          dz_d      = b_zero;
          ovf_d     = ovf;
`ifdef YSYX_23060136_DIV_FAST_SPECIAL_EN
          if (b_zero | ovf) begin
            state_d     = StDone;
            quotient_d  = wsext(divw, b_zero ? {BITS_W{1'b1}} : a_ext);
            remainder_d = wsext(divw, b_zero ? a_ext : '0);
          end
`endif
        end
      end
      StCalc: begin
        rem_d = rem_step;
        dvd_d = dvd_step;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d     = StDone;
          quotient_d  = res_q;
          remainder_d = res_r;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d     = StIdle;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      dvd_ext_q   <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      w_q         <= 1'b0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dsr_q       <= dsr_d;
      dvd_ext_q   <= dvd_ext_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      w_q         <= w_d;
      dz_q        <= dz_d;
      ovf_q       <= ovf_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign div_ready     = (state_q == StIdle);
  assign div_out_valid = (state_q == StDone) & ~flush;
  assign quotient      = quotient_q;
  assign remainder     = remainder_q;

endmodule

// File: tb/tb_ysyx_23060136_exu_div.sv
// Self-checking bench for ysyx_23060136_exu_div against an arithmetic reference model.
module tb_ysyx_23060136_exu_div;

`ifdef YSYX_23060136_DIV_FAST_SPECIAL_EN
  localparam bit Fast = 1'b1;
`else
  localparam bit Fast = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, div_valid, divw, div_signed;
  logic [63:0] dividend, divisor;
  logic        div_ready, div_out_valid;
  logic [63:0] quotient, remainder;

  int tests = 0;
  int fails = 0;

  ysyx_23060136_exu_div #(.BITS_W(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .div_valid    (div_valid),
    .divw         (divw),
    .div_signed   (div_signed),
    .dividend     (dividend),
    .divisor      (divisor),
    .div_ready    (div_ready),
    .div_out_valid(div_out_valid),
    .quotient     (quotient),
    .remainder    (remainder)
  );

  always #5 clk = ~clk;

  // RISC-V M semantics straight from the ISA rules
  function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic w,
                                input logic s, output logic [63:0] q, output logic [63:0] r,
                                output logic special);
    logic [31:0] a32, b32, q32, r32;
    int          ai, bi;
    longint      al, bl;
    a32 = a[31:0];
    b32 = b[31:0];
    special = 1'b0;
    if (w) begin
      if (b32 == 32'd0) begin
        q = '1;
        r = {{32{a32[31]}}, a32};
        special = 1'b1;
      end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q = {{32{1'b1}}, a32};
        r = '0;
        special = 1'b1;
      end else begin
        if (s) begin
          ai = a32;
          bi = b32;
          q32 = ai / bi;
          r32 = ai % bi;
        end else begin
          q32 = a32 / b32;
          r32 = a32 % b32;
        end
        q = {{32{q32[31]}}, q32};
        r = {{32{r32[31]}}, r32};
      end
    end else begin
      if (b == 64'd0) begin
        q = '1;
        r = a;
        special = 1'b1;
      end else if (s && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
        q = a;
        r = '0;
        special = 1'b1;
      end else if (s) begin
        al = a;
        bl = b;
        q = al / bl;
        r = al % bl;
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endfunction

  function automatic int exp_lat(input logic w, input logic special);
    if (special && Fast) return 1;
    return w ? 33 : 65;
  endfunction

  // Drives one request, scrambles operands after acceptance, waits (bounded) for the result
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic w, input logic s,
                        output logic [63:0] gq, output logic [63:0] gr, output int lat,
                        output logic rdy_at_valid, output logic after_valid,
                        output logic after_ready);
    @(negedge clk);
    flush = 1'b0;
    dividend = a;
    divisor = b;
    divw = w;
    div_signed = s;
    div_valid = 1'b1;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    dividend = {$urandom, $urandom};
    divisor = {$urandom, $urandom};
    divw = 1'($urandom);
    div_signed = 1'($urandom);
    lat = 1;
    @(negedge clk);
    while (!div_out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    gq = quotient;
    gr = remainder;
    rdy_at_valid = div_ready;
    @(negedge clk);
    after_valid = div_out_valid;
    after_ready = div_ready;
  endtask

  task automatic test_reset;
    #2;
    tests++;
    if (div_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", div_ready); end
    tests++;
    if (div_out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_valid got %b want 0", div_out_valid);
    end
    tests++;
    if (quotient !== 64'd0) begin fails++; $display("FAIL reset_quotient got %h want 0", quotient); end
    tests++;
    if (remainder !== 64'd0) begin fails++; $display("FAIL reset_remainder got %h want 0", remainder); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [63:0] da[6] = '{64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd7, 64'h8000_0000,
                           64'hFFFF_FFFF_FFFF_FFFB, 64'h1_8000_0000};
    logic [63:0] db[6] = '{64'd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF, 64'd0, 64'd0};
    logic        dw[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        ds[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        dsp[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [63:0] eq[6] = '{64'd14, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFD,
                           64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                           64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] er[6] = '{64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0,
                           64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_8000_0000};
    logic [63:0] gq, gr;
    int          lat;
    logic        rv, av, ar;
    for (int i = 0; i < 6; i++) begin
      run_op(da[i], db[i], dw[i], ds[i], gq, gr, lat, rv, av, ar);
      tests++;
      if (gq !== eq[i]) begin fails++; $display("FAIL dir%0d_quotient got %h want %h", i, gq, eq[i]); end
      tests++;
      if (gr !== er[i]) begin fails++; $display("FAIL dir%0d_remainder got %h want %h", i, gr, er[i]); end
      tests++;
      if (lat != exp_lat(dw[i], dsp[i])) begin
        fails++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, exp_lat(dw[i], dsp[i]));
      end
      tests++;
      if (rv !== 1'b0) begin fails++; $display("FAIL dir%0d_busy_ready got %b want 0", i, rv); end
      tests++;
      if (av !== 1'b0) begin fails++; $display("FAIL dir%0d_pulse_width got %b want 0", i, av); end
      tests++;
      if (ar !== 1'b1) begin fails++; $display("FAIL dir%0d_ready_return got %b want 1", i, ar); end
    end
  endtask

  task automatic test_random;
    logic [63:0] a, b, eq, er, gq, gr;
    logic        w, s, sp, rv, av, ar;
    int          lat;
    for (int i = 0; i < 60; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      w = 1'($urandom);
      s = 1'($urandom);
      case ($urandom_range(0, 7))
        0: b = w ? {$urandom, 32'd0} : 64'd0;
        1: begin
          s = 1'b1;
          a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
          b = w ? {$urandom, 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
        end
        2: begin
          b = 64'($urandom_range(1, 15));
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        3: a = 64'($urandom_range(0, 1000));
        default: ;
      endcase
      model(a, b, w, s, eq, er, sp);
      run_op(a, b, w, s, gq, gr, lat, rv, av, ar);
      tests++;
      if (gq !== eq) begin
        fails++; $display("FAIL rnd%0d_quotient a=%h b=%h w=%b s=%b got %h want %h", i, a, b, w, s, gq, eq);
      end
      tests++;
      if (gr !== er) begin
        fails++; $display("FAIL rnd%0d_remainder a=%h b=%h w=%b s=%b got %h want %h", i, a, b, w, s, gr, er);
      end
      tests++;
      if (lat != exp_lat(w, sp)) begin
        fails++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, exp_lat(w, sp));
      end
    end
  endtask

  task automatic test_flush;
    logic [63:0] pq, pr, gq, gr;
    int          lat;
    logic        rv, av, ar;
    pq = quotient;
    pr = remainder;
    @(negedge clk);
    dividend = 64'd1000;
    divisor = 64'd3;
    divw = 1'b0;
    div_signed = 1'b0;
    div_valid = 1'b1;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tests++;
    if (div_ready !== 1'b1) begin fails++; $display("FAIL flush_ready got %b want 1", div_ready); end
    tests++;
    if (quotient !== pq || remainder !== pr) begin
      fails++; $display("FAIL flush_hold got %h/%h want %h/%h", quotient, remainder, pq, pr);
    end
    run_op(64'd81, 64'd9, 1'b0, 1'b0, gq, gr, lat, rv, av, ar);
    tests++;
    if (gq !== 64'd9 || gr !== 64'd0) begin
      fails++; $display("FAIL flush_recover got %h/%h want 9/0", gq, gr);
    end
    tests++;
    if (lat != 65) begin fails++; $display("FAIL flush_recover_latency got %0d want 65", lat); end
  endtask

  task automatic test_flush_request;
    logic [63:0] pq, pr;
    int          seen;
    pq = quotient;
    pr = remainder;
    @(negedge clk);
    dividend = 64'd5;
    divisor = 64'd0;
    divw = 1'b0;
    div_signed = 1'b0;
    div_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    div_valid = 1'b0;
    flush = 1'b0;
    tests++;
    if (div_ready !== 1'b1) begin fails++; $display("FAIL flushreq_ready got %b want 1", div_ready); end
    seen = 0;
    repeat (70) begin
      @(negedge clk);
      if (div_out_valid === 1'b1) seen++;
    end
    tests++;
    if (seen != 0) begin fails++; $display("FAIL flushreq_no_result got %0d pulses want 0", seen); end
    tests++;
    if (quotient !== pq || remainder !== pr) begin
      fails++; $display("FAIL flushreq_hold got %h/%h want %h/%h", quotient, remainder, pq, pr);
    end
  endtask

  task automatic test_busy_ignore;
    int seen;
    int lat;
    @(negedge clk);
    dividend = 64'd1000;
    divisor = 64'd10;
    divw = 1'b0;
    div_signed = 1'b0;
    div_valid = 1'b1;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    repeat (5) @(negedge clk);
    dividend = 64'd7;
    divisor = 64'd0;
    div_valid = 1'b1;
    repeat (3) @(negedge clk);
    div_valid = 1'b0;
    lat = 0;
    while (!div_out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    tests++;
    if (quotient !== 64'd100 || remainder !== 64'd0) begin
      fails++; $display("FAIL busy_result got %h/%h want 64/0", quotient, remainder);
    end
    seen = 0;
    repeat (70) begin
      @(negedge clk);
      if (div_out_valid === 1'b1) seen++;
    end
    tests++;
    if (seen != 0) begin fails++; $display("FAIL busy_extra_result got %0d pulses want 0", seen); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] q1, r1;
    int          gap;
    @(negedge clk);
    dividend = 64'd5000;
    divisor = 64'd7;
    divw = 1'b0;
    div_signed = 1'b0;
    div_valid = 1'b1;
    gap = 0;
    @(negedge clk);
    while (!div_out_valid && gap < 200) begin
      @(negedge clk);
      gap++;
    end
    q1 = quotient;
    r1 = remainder;
    dividend = 64'd999;
    divisor = 64'd4;
    gap = 1;
    @(negedge clk);
    while (!div_out_valid && gap < 200) begin
      @(negedge clk);
      gap++;
    end
    div_valid = 1'b0;
    tests++;
    if (q1 !== 64'd714 || r1 !== 64'd2) begin
      fails++; $display("FAIL b2b_first got %h/%h want 714/2", q1, r1);
    end
    tests++;
    if (quotient !== 64'd249 || remainder !== 64'd3) begin
      fails++; $display("FAIL b2b_second got %h/%h want 249/3", quotient, remainder);
    end
    tests++;
    if (gap != 66) begin fails++; $display("FAIL b2b_throughput got %0d want 66", gap); end
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    logic [63:0] gq, gr;
    int          lat;
    logic        rv, av, ar;
    @(negedge clk);
    dividend = 64'd12345;
    divisor = 64'd7;
    divw = 1'b0;
    div_signed = 1'b0;
    div_valid = 1'b1;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (div_ready !== 1'b1 || div_out_valid !== 1'b0) begin
      fails++; $display("FAIL async_rst_ctrl got ready=%b valid=%b want 1/0", div_ready, div_out_valid);
    end
    tests++;
    if (quotient !== 64'd0 || remainder !== 64'd0) begin
      fails++; $display("FAIL async_rst_data got %h/%h want 0/0", quotient, remainder);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(64'd81, 64'd9, 1'b0, 1'b0, gq, gr, lat, rv, av, ar);
    tests++;
    if (gq !== 64'd9 || gr !== 64'd0 || lat != 65) begin
      fails++; $display("FAIL async_rst_recover got %h/%h lat %0d want 9/0 lat 65", gq, gr, lat);
    end
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    div_valid = 1'b0;
    divw = 1'b0;
    div_signed = 1'b0;
    dividend = '0;
    divisor = '0;
    test_reset;
    test_directed;
    test_random;
    test_flush;
    test_flush_request;
    test_busy_ignore;
    test_back_to_back;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
